// File: rtl/dac_serial_rx_if.sv
// Output word stream of the DAC serial receiver: head-of-FIFO data with valid/ready.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface dac_serial_rx_if #(
    parameter int DW = 16
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/dac_serial_rx.sv
// 3-wire (sclk/sdi/cs_n) frame receiver: oversamples the link on aclk, rebuilds MSB-first
// DW-bit words, rejects frames of the wrong length and queues good words in a FWFT FIFO.
//
// state       | meaning
// WAIT_IDLE   | wait until cs_n is seen high after reset/enable so a running frame is skipped
// IDLE        | link idle, waiting for a cs_n falling edge
// SHIFT       | frame open, shifting one bit per sclk rise until cs_n rises
module dac_serial_rx #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     en,
    input  logic                     sclk,
    input  logic                     sdi,
    input  logic                     cs_n,
    dac_serial_rx_if.master          m_if,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int CW = $clog2(DW + 2);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SYNC + 1);

    typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_SHIFT} state_t;

    state_t          r_state;
    state_t          w_next;

    logic [SYNC-1:0] r_sclk_sync;
    logic [SYNC-1:0] r_sdi_sync;
    logic [SYNC-1:0] r_cs_sync;
    logic            r_sclk_hist;
    logic            r_cs_hist;
    logic [SW-1:0]   r_settle;

    logic [DW-1:0]   r_shift;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   w_shift_next;
    logic [CW-1:0]   w_cnt_next;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [LW-1:0]   r_level;
    logic            r_frame_err;
    logic            r_overflow;
    logic [7:0]      r_err_count;

    logic w_sclk_s, w_sdi_s, w_cs_s;
    logic w_sclk_rise, w_cs_fall, w_cs_rise;
    logic w_clear, w_shift_en, w_push, w_err;
    logic w_pop, w_full, w_wr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_sclk_sync <= '1;
            r_sdi_sync  <= '1;
            r_cs_sync   <= '1;
            r_sclk_hist <= 1'b1;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC-2:0], sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC-2:0], sdi};
            r_cs_sync   <= {r_cs_sync[SYNC-2:0], cs_n};
            r_sclk_hist <= r_sclk_sync[SYNC-1];
            r_cs_hist   <= r_cs_sync[SYNC-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC-1];
    assign w_sdi_s     = r_sdi_sync[SYNC-1];
    assign w_cs_s      = r_cs_sync[SYNC-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_cs_fall   = ~w_cs_s & r_cs_hist;
    assign w_cs_rise   = w_cs_s & ~r_cs_hist;

    // Synchronizers come out of reset all-ones, so cs_n only counts as high once the
    // raw pin value has had time to reach the last stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_settle <= SW'(SYNC);
        end else if (r_state != S_WAIT_IDLE || !en || !w_cs_s) begin
            r_settle <= SW'(SYNC);
        end else if (r_settle != '0) begin
            r_settle <= r_settle - SW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_WAIT_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = S_WAIT_IDLE;
        end else begin
            case (r_state)
                S_WAIT_IDLE: if (r_settle == '0 && w_cs_s) w_next = S_IDLE;
                S_IDLE:      if (w_cs_fall) w_next = S_SHIFT;
                S_SHIFT:     if (w_cs_rise) w_next = S_IDLE;
                default:     w_next = S_WAIT_IDLE;
            endcase
        end
    end

    // A bit arriving in the same cycle as cs_n rise is folded in before the length check.
    assign w_cnt_next   = (w_sclk_rise && r_cnt != CW'(DW + 1)) ? r_cnt + CW'(1) : r_cnt;
    assign w_shift_next = w_sclk_rise ? {r_shift[DW-2:0], w_sdi_s} : r_shift;

    always_comb begin
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        w_push     = 1'b0;
        w_err      = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE:  w_clear = w_cs_fall;
                S_SHIFT: begin
                    w_shift_en = 1'b1;
                    if (w_cs_rise) begin
                        w_push = (w_cnt_next == CW'(DW));
                        w_err  = (w_cnt_next != CW'(DW));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_pop  = m_if.m_valid & m_if.m_ready;
    assign w_full = (r_level == LW'(DEPTH));
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_level     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= w_shift_next;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
            r_frame_err <= w_err;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign m_if.m_data  = r_mem[r_rd];
    assign m_if.m_valid = (r_level != '0);
    assign frame_err    = r_frame_err;
    assign overflow     = r_overflow;
    assign err_count    = r_err_count;
    assign level        = r_level;
endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: drives 3-wire frames at aclk/4 and scores received words
// against a queue of expected words pushed when each frame is sent.
module tb_dac_serial_rx;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       aclk   = 1'b0;
    logic       areset = 1'b1;
    logic       en     = 1'b1;
    logic       sclk   = 1'b0;
    logic       sdi    = 1'b0;
    logic       cs_n   = 1'b1;
    logic       frame_err;
    logic       overflow;
    logic [7:0] err_count;
    logic [2:0] level;

    dac_serial_rx_if #(.DW(DW)) m_if ();

    dac_serial_rx #(.DW(DW), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en),
        .sclk      (sclk),
        .sdi       (sdi),
        .cs_n      (cs_n),
        .m_if      (m_if),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_count (err_count),
        .level     (level)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdi  = w[i];
            cyc(2);
            sclk = 1'b1;
            cyc(2);
        end
        sclk = 1'b0;
    endtask

    task automatic frame_open();
        cyc(4);
        cs_n = 1'b0;
        cyc(2);
    endtask

    task automatic frame_close();
        cyc(2);
        cs_n = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        frame_open();
        send_bits(w, n);
        frame_close();
    endtask

    // Waits (bounded) for m_valid, scores the head word, then steps past the pop cycle.
    task automatic expect_pop(input string tag, output int lat);
        logic [31:0] expv;
        lat = 0;
        while (!m_if.m_valid && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        chk({tag, "_valid"}, m_if.m_valid, 1);
        expv = (exp_q.size() != 0) ? {16'h0, exp_q.pop_front()} : 32'hDEAD0000;
        chk({tag, "_data"}, m_if.m_data, expv);
        @(negedge aclk);
    endtask

    task automatic expect_err(input string tag);
        int k = 0;
        while (!frame_err && k < 12) begin
            @(negedge aclk);
            k++;
        end
        chk({tag, "_pulse"}, frame_err, 1);
        @(negedge aclk);
        chk({tag, "_pulse_end"}, frame_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        m_if.m_ready = 1'b1;
        cyc(3);
        chk("rst_valid", m_if.m_valid, 0);
        chk("rst_data", m_if.m_data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_ferr", frame_err, 0);
        areset = 1'b0;
        cyc(8);

        // basic frames
        exp_q.push_back(16'hA5C3);
        send_frame(32'hA5C3, 16);
        expect_pop("a5c3", lat);
        chk("a5c3_latency", (lat <= SYNC + 2), 1);
        chk("a5c3_one_cycle", m_if.m_valid, 0);
        exp_q.push_back(16'h0000);
        send_frame(32'h0000, 16);
        expect_pop("w0000", lat);
        exp_q.push_back(16'hFFFF);
        send_frame(32'hFFFF, 16);
        expect_pop("wffff", lat);
        chk("basic_empty", m_if.m_valid, 0);

        // wrong length
        send_frame(32'h7FFF, 15);
        expect_err("len15");
        chk("len15_cnt", err_count, 1);
        send_frame(32'h1ABCD, 17);
        expect_err("len17");
        chk("len17_cnt", err_count, 2);
        chk("badlen_level", level, 0);
        chk("badlen_valid", m_if.m_valid, 0);
        exp_q.push_back(16'h1234);
        send_frame(32'h1234, 16);
        expect_pop("w1234", lat);

        // backpressure and overflow
        m_if.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(16'(i));
            send_frame(32'(i), 16);
        end
        cyc(6);
        chk("bp_level", level, 4);
        chk("bp_ovf", overflow, 1);
        chk("bp_head", m_if.m_data, 16'h0001);
        m_if.m_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) expect_pop("bp_pop", lat);
        cyc(2);
        chk("bp_drained", m_if.m_valid, 0);
        chk("bp_queue", exp_q.size(), 0);
        chk("bp_ovf_sticky", overflow, 1);

        // reset clears sticky state
        areset = 1'b1;
        cyc(2);
        chk("rst2_ovf", overflow, 0);
        chk("rst2_errcnt", err_count, 0);
        chk("rst2_level", level, 0);
        chk("rst2_data", m_if.m_data, 0);
        areset = 1'b0;
        cyc(6);

        // full with simultaneous pop in the push cycle
        m_if.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(16'h0011 + 16'(i));
            send_frame(32'h0011 + 32'(i), 16);
        end
        cyc(6);
        chk("fp_full", level, 4);
        exp_q.push_back(16'h0015);
        frame_open();
        send_bits(32'h0015, 16);
        frame_close();
        cyc(2);
        chk("fp_head_valid", m_if.m_valid, 1);
        chk("fp_head_data", m_if.m_data, {16'h0, exp_q.pop_front()});
        m_if.m_ready = 1'b1;
        cyc(1);
        m_if.m_ready = 1'b0;
        chk("fp_level", level, 4);
        chk("fp_ovf", overflow, 0);
        cyc(2);
        m_if.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) expect_pop("fp_pop", lat);
        chk("fp_empty", level, 0);

        // areset mid-frame
        frame_open();
        send_bits(32'hAB, 8);
        areset = 1'b1;
        cyc(2);
        areset = 1'b0;
        send_bits(32'hCD, 8);
        frame_close();
        cyc(10);
        chk("midrst_valid", m_if.m_valid, 0);
        chk("midrst_errcnt", err_count, 0);
        exp_q.push_back(16'hBEEF);
        send_frame(32'hBEEF, 16);
        expect_pop("midrst_beef", lat);

        // en dropped mid-frame
        frame_open();
        send_bits(32'hAB, 8);
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        send_bits(32'hCD, 8);
        frame_close();
        cyc(10);
        chk("miden_valid", m_if.m_valid, 0);
        chk("miden_errcnt", err_count, 0);
        exp_q.push_back(16'hBEEF);
        send_frame(32'hBEEF, 16);
        expect_pop("miden_beef", lat);

        // error counter saturation
        for (int i = 1; i <= 260; i++) begin
            send_frame(32'h5, 3);
            if (i == 254) begin
                cyc(6);
                chk("sat_254", err_count, 254);
            end
            if (i == 255) begin
                cyc(6);
                chk("sat_255", err_count, 255);
            end
        end
        cyc(6);
        chk("sat_hold", err_count, 255);
        chk("sat_no_word", m_if.m_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_serial_rx.md
Name: dac_serial_rx

Overview:
- Serial frame receiver for the 3-wire DAC link (`sclk`, `sdi`, `cs_n`), MSB first, one word per `cs_n` low window.
- Oversamples the link on the system clock and rebuilds each DW-bit word.
- Checks the frame length and queues good words in a small FIFO with a valid/ready output.
- Serves as a loopback/capture endpoint for the DAC transmit path and as the FPGA-side receiver when the FPGA is the serial target.

Parameters:
- DW, 16, word width and required bits per frame.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SYNC, 2, synchronizer flops per serial input; ≥2.

Ports:
- aclk  in  1  system clock; must be ≥4× sclk frequency.
- areset  in  1  asynchronous active-high reset.
- en  in  1  receive enable.
- sclk  in  1  serial clock, asynchronous to aclk; data is sampled on its rising edge.
- sdi  in  1  serial data, asynchronous.
- cs_n  in  1  frame select, active low, asynchronous.
- m_data  out  DW  head-of-FIFO word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts m_data.
- frame_err  out  1  one-cycle pulse when a frame is discarded for wrong length.
- overflow  out  1  sticky; a good frame arrived while the FIFO was full.
- err_count  out  8  count of frame errors, saturates at 255.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: m_data=0, m_valid=0, frame_err=0, overflow=0, err_count=0, level=0, FSM=WAIT_IDLE, all synchronizer flops=1.
- Input conditioning:
  - sclk, sdi and cs_n each pass through SYNC flops, then one extra history flop.
  - sclk rise = sync=1 and history=0; cs_n fall and rise are detected the same way.
  - sdi is taken from the synchronized stage in the cycle the sclk rise is detected.
- FSM:
  - WAIT_IDLE: leave only when synchronized cs_n=1, then go to IDLE. This stops a frame already in progress at reset release or at en rise from being captured.
  - IDLE: on cs_n fall with en=1, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each sclk rise, shift_reg <= {shift_reg[DW-2:0], sdi}. The bit counter increments and saturates at DW+1.
  - SHIFT, on cs_n rise: if count==DW, push shift_reg to the FIFO, else pulse frame_err and increment err_count. Either way return to IDLE.
  - sclk rise and cs_n rise in the same cycle: the bit is counted first, then the length check runs.
  - en=0 in any state: FSM goes to WAIT_IDLE and any partial frame is dropped with no error. The FIFO output side keeps operating.
- Latency: word written on the aclk edge after the synchronized cs_n rise is detected. m_valid is high no later than SYNC+2 aclk cycles after the raw cs_n rising edge.
- FIFO:
  - First-word-fall-through registered output; m_data holds the head entry whenever m_valid=1.
  - Pop occurs when m_valid and m_ready are both high.
  - Push into an empty FIFO: m_valid rises the next cycle; there is no same-cycle bypass.
  - Push while full with no pop: the word is dropped and overflow sets (sticky until areset). FIFO contents are unchanged.
  - Push while full with a simultaneous pop: both are accepted, level unchanged, no overflow.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - Pointers wrap modulo DEPTH; level counts 0..DEPTH.
- areset mid-frame: everything returns to reset values, the partial frame is lost and FIFO contents are cleared.

Test Plan:
- Basic frames: one frame 0xA5C3 (16 sclk, sclk=aclk/4), m_ready=1 → m_data=0xA5C3 with m_valid high for exactly one cycle, within SYNC+2 cycles of cs_n rise. Then 0x0000 and 0xFFFF → received in order.
- Wrong length: a 15-bit frame and a 17-bit frame → frame_err pulses twice, err_count=2, nothing pushed. A following 16-bit frame 0x1234 is received normally.
- Backpressure and overflow: m_ready=0, send 5 frames 0x0001..0x0005 → level=4, overflow=1, m_data=0x0001. Raise m_ready → pops 0x0001..0x0004, 0x0005 is absent.
- Full with simultaneous pop: FIFO full and m_ready=1 in the same cycle a new frame completes → frame accepted, overflow stays 0, level stays 4.
- Reset and enable mid-frame: areset asserted after 8 bits, released with cs_n still low → the remainder of that frame is ignored (no word, no error), and the next full frame 0xBEEF is received. Repeat by dropping en mid-frame → same result.
- Error counter saturation: 260 frames of 3 bits each → err_count=255 and holds there.
